axi_lite_arbiter: RTL and testbench

Two-to-one AXI-Lite arbiter: shares one downstream AXI-Lite slave between two upstream masters. Write (AW/W/B) and read (AR/R) paths are arbitrated independently, each with one outstanding transaction. It sits in front of shared peripherals or in front of an `axi_lite_buf` feeding them.

---
 rtl/axi_lite_arbiter_if.sv | 33 +++
 rtl/axi_lite_arbiter.sv | 143 ++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_arbiter_if.sv
// axi_lite_channel: AXI-Lite bus bundle with master/slave views; widths set by ADDR_W/DATA_W.
interface axi_lite_channel #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                aw_valid;
    logic                aw_ready;
    logic [ADDR_W-1:0]   aw_addr;
    logic                w_valid;
    logic                w_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                b_valid;
    logic                b_ready;
    logic [1:0]          b_resp;
    logic                ar_valid;
    logic                ar_ready;
    logic [ADDR_W-1:0]   ar_addr;
    logic                r_valid;
    logic                r_ready;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: 2:1 AXI-Lite arbiter, independent write/read FSMs; AXI_LITE_ARB_RR_EN selects round-robin over fixed priority.
module axi_lite_arbiter (
    input logic            clk,
    input logic            rstn,
    axi_lite_channel.slave  master0,
    axi_lite_channel.slave  master1,
    axi_lite_channel.master slave
);
    if ($bits(master0.aw_addr) != $bits(slave.aw_addr) || $bits(master1.aw_addr) != $bits(slave.aw_addr) ||
        $bits(master0.w_data) != $bits(slave.w_data) || $bits(master1.w_data) != $bits(slave.w_data)) begin : g_width_check
        $fatal(1, "axi_lite_arbiter: interface widths differ");
    end

    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_RESP} wr_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_RESP} rd_state_e;

    wr_state_e wst_q, wst_d;
    rd_state_e rst_q, rst_d;
    logic wgnt_q, wgnt_d, wlast_q, wlast_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic rgnt_q, rgnt_d, rlast_q, rlast_d, ar_done_q, ar_done_d;
    logic w_addr_ph, w_resp_ph, r_addr_ph, r_resp_ph;
    logic wpick, rpick, aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;

    assign w_addr_ph = wst_q == WR_ADDR;
    assign w_resp_ph = wst_q == WR_RESP;
    assign r_addr_ph = rst_q == RD_ADDR;
    assign r_resp_ph = rst_q == RD_RESP;

`ifdef AXI_LITE_ARB_RR_EN
    assign wpick = (master0.aw_valid & master1.aw_valid) ? ~wlast_q : master1.aw_valid;
    assign rpick = (master0.ar_valid & master1.ar_valid) ? ~rlast_q : master1.ar_valid;
`else
    assign wpick = ~master0.aw_valid;
    assign rpick = ~master0.ar_valid;
`endif

    assign slave.aw_valid = w_addr_ph & ~aw_done_q & (wgnt_q ? master1.aw_valid : master0.aw_valid);
    assign slave.aw_addr  = wgnt_q ? master1.aw_addr : master0.aw_addr;
    assign slave.w_valid  = w_addr_ph & ~w_done_q & (wgnt_q ? master1.w_valid : master0.w_valid);
    assign slave.w_data   = wgnt_q ? master1.w_data : master0.w_data;
    assign slave.w_strb   = wgnt_q ? master1.w_strb : master0.w_strb;
    assign slave.b_ready  = w_resp_ph & (wgnt_q ? master1.b_ready : master0.b_ready);
    assign slave.ar_valid = r_addr_ph & ~ar_done_q & (rgnt_q ? master1.ar_valid : master0.ar_valid);
    assign slave.ar_addr  = rgnt_q ? master1.ar_addr : master0.ar_addr;
    assign slave.r_ready  = r_resp_ph & (rgnt_q ? master1.r_ready : master0.r_ready);

    assign aw_rdy = w_addr_ph & ~aw_done_q & slave.aw_ready;
    assign w_rdy  = w_addr_ph & ~w_done_q & slave.w_ready;
    assign b_vld  = w_resp_ph & slave.b_valid;
    assign ar_rdy = r_addr_ph & ~ar_done_q & slave.ar_ready;
    assign r_vld  = r_resp_ph & slave.r_valid;

    assign master0.aw_ready = ~wgnt_q & aw_rdy;
    assign master1.aw_ready = wgnt_q & aw_rdy;
    assign master0.w_ready  = ~wgnt_q & w_rdy;
    assign master1.w_ready  = wgnt_q & w_rdy;
    assign master0.b_valid  = ~wgnt_q & b_vld;
    assign master1.b_valid  = wgnt_q & b_vld;
    assign master0.b_resp   = slave.b_resp;
    assign master1.b_resp   = slave.b_resp;
    assign master0.ar_ready = ~rgnt_q & ar_rdy;
    assign master1.ar_ready = rgnt_q & ar_rdy;
    assign master0.r_valid  = ~rgnt_q & r_vld;
    assign master1.r_valid  = rgnt_q & r_vld;
    assign master0.r_data   = slave.r_data;
    assign master1.r_data   = slave.r_data;
    assign master0.r_resp   = slave.r_resp;
    assign master1.r_resp   = slave.r_resp;

    // Write path: grant on AW request, collect AW and W handshakes, wait for B.
    always_comb begin
        wst_d     = wst_q;
        wgnt_d    = wgnt_q;
        wlast_d   = wlast_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        if (wst_q == WR_IDLE) begin
            if (master0.aw_valid | master1.aw_valid) begin
                wgnt_d  = wpick;
                wlast_d = wpick;
                wst_d   = WR_ADDR;
            end
        end else if (w_addr_ph) begin
            aw_done_d = aw_done_q | (slave.aw_valid & slave.aw_ready);
            w_done_d  = w_done_q | (slave.w_valid & slave.w_ready);
            if (aw_done_d & w_done_d) begin
                wst_d     = WR_RESP;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        end else if (slave.b_valid & slave.b_ready) begin
            wst_d = WR_IDLE;
        end
    end

    // Read path: grant on AR request, one AR handshake, wait for R.
    always_comb begin
        rst_d     = rst_q;
        rgnt_d    = rgnt_q;
        rlast_d   = rlast_q;
        ar_done_d = ar_done_q;
        if (rst_q == RD_IDLE) begin
            if (master0.ar_valid | master1.ar_valid) begin
                rgnt_d  = rpick;
                rlast_d = rpick;
                rst_d   = RD_ADDR;
            end
        end else if (r_addr_ph) begin
            ar_done_d = ar_done_q | (slave.ar_valid & slave.ar_ready);
            if (ar_done_d) begin
                rst_d     = RD_RESP;
                ar_done_d = 1'b0;
            end
        end else if (slave.r_valid & slave.r_ready) begin
            rst_d = RD_IDLE;
        end
    end

    // State registers; last pointers reset to master1 so master0 wins the first contention.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wst_q     <= WR_IDLE;
            wgnt_q    <= 1'b0;
            wlast_q   <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rst_q     <= RD_IDLE;
            rgnt_q    <= 1'b0;
            rlast_q   <= 1'b1;
            ar_done_q <= 1'b0;
        end else begin
            wst_q     <= wst_d;
            wgnt_q    <= wgnt_d;
            wlast_q   <= wlast_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rst_q     <= rst_d;
            rgnt_q    <= rgnt_d;
            rlast_q   <= rlast_d;
            ar_done_q <= ar_done_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed self-checking bench for axi_lite_arbiter (both AXI_LITE_ARB_RR_EN builds).
module tb_axi_lite_arbiter;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int n_vec = 0;
    int n_err = 0;

    axi_lite_channel m0_if ();
    axi_lite_channel m1_if ();
    axi_lite_channel s_if ();

    axi_lite_arbiter dut (
        .clk     (clk),
        .rstn    (rstn),
        .master0 (m0_if),
        .master1 (m1_if),
        .slave   (s_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        {m0_if.aw_valid, m0_if.w_valid, m0_if.b_ready, m0_if.ar_valid, m0_if.r_ready} = '0;
        {m1_if.aw_valid, m1_if.w_valid, m1_if.b_ready, m1_if.ar_valid, m1_if.r_ready} = '0;
        m0_if.aw_addr = '0; m0_if.w_data = '0; m0_if.w_strb = '0; m0_if.ar_addr = '0;
        m1_if.aw_addr = '0; m1_if.w_data = '0; m1_if.w_strb = '0; m1_if.ar_addr = '0;
        {s_if.aw_ready, s_if.w_ready, s_if.b_valid, s_if.ar_ready, s_if.r_valid} = '0;
        s_if.b_resp = '0; s_if.r_resp = '0; s_if.r_data = '0;
    endtask

    logic [7:0] order;
    logic [7:0] exp_order;
    int k, c0, c1;

    initial begin
        clear_all();
        #1;
        check("rst_slave_valids", {s_if.aw_valid, s_if.w_valid, s_if.ar_valid, s_if.b_ready, s_if.r_ready}, 0);
        check("rst_m_readies", {m0_if.aw_ready, m0_if.w_ready, m0_if.ar_ready, m1_if.aw_ready, m1_if.w_ready, m1_if.ar_ready}, 0);
        tick();
        tick();
        rstn = 1'b1;

        // single write from master0
        m0_if.aw_valid = 1; m0_if.aw_addr = 32'h10; m0_if.w_valid = 1; m0_if.w_data = 32'hDEADBEEF;
        m0_if.w_strb = 4'hF; m0_if.b_ready = 1; s_if.aw_ready = 1; s_if.w_ready = 1;
        #1;
        check("w1_idle_awvalid", s_if.aw_valid, 0);
        check("w1_idle_awready", m0_if.aw_ready, 0);
        tick();
        check("w1_awvalid", s_if.aw_valid, 1);
        check("w1_awaddr", s_if.aw_addr, 32'h10);
        check("w1_wdata", s_if.w_data, 32'hDEADBEEF);
        check("w1_wstrb", s_if.w_strb, 4'hF);
        check("w1_m0_readies", {m0_if.aw_ready, m0_if.w_ready}, 2'b11);
        check("w1_m1_readies", {m1_if.aw_ready, m1_if.w_ready}, 2'b00);
        tick();
        m0_if.aw_valid = 0; m0_if.w_valid = 0;
        #1;
        check("w1_resp_awvalid", s_if.aw_valid, 0);
        check("w1_resp_bready", s_if.b_ready, 1);
        check("w1_wait_bvalid", {m0_if.b_valid, m1_if.b_valid}, 0);
        tick();
        tick();
        s_if.b_valid = 1; s_if.b_resp = 2'b00;
        #1;
        check("w1_m0_bvalid", m0_if.b_valid, 1);
        check("w1_m0_bresp", m0_if.b_resp, 0);
        check("w1_m1_bvalid", m1_if.b_valid, 0);
        tick();
        s_if.b_valid = 0;
        #1;
        check("w1_back_idle", s_if.b_ready, 0);

        // spurious B in WR_IDLE
        s_if.b_valid = 1;
        #1;
        check("spur_bready", s_if.b_ready, 0);
        check("spur_m_bvalid", {m0_if.b_valid, m1_if.b_valid}, 0);
        s_if.b_valid = 0;

        // contention: 4 writes each, fresh reset so master0 wins the first
        rstn = 0;
        tick();
        rstn = 1;
        m0_if.aw_valid = 1; m0_if.aw_addr = 32'h100; m0_if.w_valid = 1; m0_if.w_data = 32'hA0; m0_if.b_ready = 1;
        m1_if.aw_valid = 1; m1_if.aw_addr = 32'h200; m1_if.w_valid = 1; m1_if.w_data = 32'hB1; m1_if.b_ready = 1;
        s_if.b_valid = 1;
        order = '0; k = 0; c0 = 0; c1 = 0;
`ifdef AXI_LITE_ARB_RR_EN
        exp_order = 8'b1010_1010;
`else
        exp_order = 8'b1111_0000;
`endif
        #1;
        for (int cyc = 0; cyc < 60 && !(c0 == 4 && c1 == 4); cyc++) begin
            if (m0_if.aw_ready) begin
                if (k < 8) order[k] = 1'b0;
                check("c_addr0", s_if.aw_addr, 32'h100);
                k++;
            end
            if (m1_if.aw_ready) begin
                if (k < 8) order[k] = 1'b1;
                check("c_addr1", s_if.aw_addr, 32'h200);
                k++;
            end
            if (m0_if.b_valid) begin
                c0++;
                if (c0 == 4) begin m0_if.aw_valid = 0; m0_if.w_valid = 0; end
            end
            if (m1_if.b_valid) begin
                c1++;
                if (c1 == 4) begin m1_if.aw_valid = 0; m1_if.w_valid = 0; end
            end
            tick();
        end
        check("c_order", order, exp_order);
        check("c_grants", k, 8);
        check("c_b0", c0, 4);
        check("c_b1", c1, 4);
        clear_all();

        // master1 W before AW
        s_if.w_ready = 1; s_if.aw_ready = 1; m1_if.b_ready = 1;
        m1_if.w_valid = 1; m1_if.w_data = 32'hCAFE0001; m1_if.w_strb = 4'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("early_w_ready", m1_if.w_ready, 0);
            check("early_s_wvalid", s_if.w_valid, 0);
            tick();
        end
        m1_if.aw_valid = 1; m1_if.aw_addr = 32'h44;
        #1;
        check("early_idle_wready", m1_if.w_ready, 0);
        tick();
        check("early_granted", {m1_if.aw_ready, m1_if.w_ready}, 2'b11);
        check("early_wdata", s_if.w_data, 32'hCAFE0001);
        check("early_awaddr", s_if.aw_addr, 32'h44);
        tick();
        m1_if.aw_valid = 0; m1_if.w_valid = 0;
        s_if.b_valid = 1; s_if.b_resp = 2'b10;
        #1;
        check("early_b", {m1_if.b_valid, m0_if.b_valid}, 2'b10);
        check("early_bresp", m1_if.b_resp, 2'b10);
        tick();
        clear_all();

        // concurrent master0 read and master1 write
        m0_if.ar_valid = 1; m0_if.ar_addr = 32'h20; m0_if.r_ready = 1;
        m1_if.aw_valid = 1; m1_if.aw_addr = 32'h30; m1_if.w_valid = 1; m1_if.w_data = 32'h55; m1_if.b_ready = 1;
        s_if.ar_ready = 1; s_if.aw_ready = 1; s_if.w_ready = 1;
        tick();
        check("cc_valids", {s_if.ar_valid, s_if.aw_valid, s_if.w_valid}, 3'b111);
        check("cc_araddr", s_if.ar_addr, 32'h20);
        check("cc_awaddr", s_if.aw_addr, 32'h30);
        check("cc_readies", {m0_if.ar_ready, m1_if.aw_ready, m1_if.ar_ready, m0_if.aw_ready}, 4'b1100);
        tick();
        m0_if.ar_valid = 0; m1_if.aw_valid = 0; m1_if.w_valid = 0;
        s_if.r_valid = 1; s_if.r_data = 32'h1234; s_if.r_resp = 2'b10; s_if.b_valid = 1; s_if.b_resp = 2'b00;
        #1;
        check("cc_rvalid", {m0_if.r_valid, m1_if.r_valid}, 2'b10);
        check("cc_rdata", m0_if.r_data, 32'h1234);
        check("cc_rresp", m0_if.r_resp, 2'b10);
        check("cc_bvalid", {m1_if.b_valid, m0_if.b_valid}, 2'b10);
        tick();
        clear_all();

        // reset pulse while in WR_RESP
        m0_if.aw_valid = 1; m0_if.w_valid = 1; m0_if.b_ready = 1; s_if.aw_ready = 1; s_if.w_ready = 1;
        tick();
        tick();
        m0_if.aw_valid = 0; m0_if.w_valid = 0; s_if.b_valid = 1;
        #1;
        check("rp_in_resp", {s_if.b_ready, m0_if.b_valid}, 2'b11);
        rstn = 0;
        #1;
        check("rp_slave", {s_if.aw_valid, s_if.w_valid, s_if.ar_valid, s_if.b_ready, s_if.r_ready}, 0);
        check("rp_master", {m0_if.b_valid, m0_if.aw_ready, m0_if.w_ready, m1_if.b_valid, m1_if.aw_ready}, 0);
        s_if.b_valid = 0;
        tick();
        rstn = 1;
        m0_if.aw_valid = 1; m1_if.aw_valid = 1;
        tick();
        check("rp_first_win", {m0_if.aw_ready, m1_if.aw_ready}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
